block_stream_gen: RTL

- Transmitter side of the BlockChecker character-stream interface.
- Accepts word tokens through a valid/ready handshake and buffers them in a small FIFO.
- Serialises each token as ASCII bytes, one byte per clock, with a space (8'h20) after every word.
- Tracks begin/end nesting of the emitted stream and drives `expect_result`, the value a correct checker must produce.
- Used as the stimulus source and scoreboard in the P1 checker benches.

---
 rtl/block_stream_gen.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/block_stream_gen.sv
// Token-to-ASCII stream transmitter for the BlockChecker interface.
// Buffers word tokens in a FIFO, serialises them with space separators and tracks nesting.
module block_stream_gen #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tok_valid,
   input  logic [1:0]       tok_type,
   input  logic             tok_upper,
   output logic             tok_ready,
   output logic [7:0]       out,
   output logic             out_valid,
   output logic             expect_result,
   output logic [CNT_W-1:0] depth,
   output logic             busy
);
   localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned FCNT_W = $clog2(DEPTH + 1);
   localparam logic [1:0]  T_BEGIN = 2'b00;
   localparam logic [1:0]  T_END   = 2'b01;
   localparam logic [1:0]  T_A     = 2'b10;
   localparam logic [7:0]  SPACE   = 8'h20;

   typedef enum logic [1:0] {S_IDLE, S_EMIT, S_SEP} state_t;

   state_t              state, state_nxt;
   logic [1:0]          fifo_type  [DEPTH];
   logic                fifo_upper [DEPTH];
   logic [PTR_W-1:0]    wr_ptr, rd_ptr;
   logic [FCNT_W-1:0]   count;
   logic                push, pop, fifo_empty;
   logic [1:0]          cur_type, cur_type_nxt;
   logic                cur_upper, cur_upper_nxt;
   logic [2:0]          idx, idx_nxt;
   logic [7:0]          out_nxt;
   logic                valid_nxt, err, err_nxt;
   logic [CNT_W-1:0]    depth_nxt;

   // Letter i of a word; only the first letter honours the uppercase flag.
   function automatic logic [7:0] letter(input logic [1:0] t, input logic [2:0] i, input logic up);
      logic [7:0] c;
      c = SPACE;
      case (t)
         T_BEGIN: case (i)
            3'd0: c = 8'h62;  3'd1: c = 8'h65;  3'd2: c = 8'h67;  3'd3: c = 8'h69;
            default: c = 8'h6E;
         endcase
         T_END: case (i)
            3'd0: c = 8'h65;  3'd1: c = 8'h6E;
            default: c = 8'h64;
         endcase
         T_A: c = 8'h61;
         default: case (i)
            3'd0: c = 8'h65;  3'd1: c = 8'h6E;  3'd2: c = 8'h64;
            default: c = 8'h73;
         endcase
      endcase
      if (up && i == 3'd0) c = c - 8'h20;
      return c;
   endfunction

   function automatic logic [2:0] word_len(input logic [1:0] t);
      case (t)
         T_BEGIN: return 3'd5;
         T_END:   return 3'd3;
         T_A:     return 3'd1;
         default: return 3'd4;
      endcase
   endfunction

   assign fifo_empty = (count == '0);
   assign tok_ready  = (count != FCNT_W'(DEPTH));
   assign push       = tok_valid && tok_ready;
   assign busy       = !fifo_empty || (state != S_IDLE);

   // Token FIFO storage; contents are don't-care while the count says empty.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_type[wr_ptr]  <= tok_type;
         fifo_upper[wr_ptr] <= tok_upper;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      count <= count + FCNT_W'(1);
         else if (pop && !push) count <= count - FCNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (!fifo_empty) state_nxt = S_EMIT;
         S_EMIT:  if (idx == word_len(cur_type)) state_nxt = S_SEP;
         S_SEP:   state_nxt = fifo_empty ? S_IDLE : S_EMIT;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Next byte, token pickup and nesting update (nesting commits when leaving SEP).
   always_comb begin
      pop           = 1'b0;
      out_nxt       = SPACE;
      valid_nxt     = 1'b0;
      idx_nxt       = idx;
      cur_type_nxt  = cur_type;
      cur_upper_nxt = cur_upper;
      depth_nxt     = depth;
      err_nxt       = err;
      case (state)
         S_IDLE: pop = !fifo_empty;
         S_EMIT: begin
            valid_nxt = 1'b1;
            if (idx != word_len(cur_type)) begin
               out_nxt = letter(cur_type, idx, cur_upper);
               idx_nxt = idx + 3'd1;
            end
         end
         S_SEP: begin
            pop = !fifo_empty;
            if (cur_type == T_BEGIN) begin
               if (depth != {CNT_W{1'b1}}) depth_nxt = depth + CNT_W'(1);
            end else if (cur_type == T_END) begin
               if (depth != '0) depth_nxt = depth - CNT_W'(1);
               else             err_nxt   = 1'b1;
            end
         end
         default: ;
      endcase
      if (pop) begin
         cur_type_nxt  = fifo_type[rd_ptr];
         cur_upper_nxt = fifo_upper[rd_ptr];
         out_nxt       = letter(fifo_type[rd_ptr], 3'd0, fifo_upper[rd_ptr]);
         valid_nxt     = 1'b1;
         idx_nxt       = 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out           <= SPACE;
         out_valid     <= 1'b0;
         idx           <= '0;
         cur_type      <= T_A;
         cur_upper     <= 1'b0;
         depth         <= '0;
         err           <= 1'b0;
         expect_result <= 1'b1;
      end else begin
         out           <= out_nxt;
         out_valid     <= valid_nxt;
         idx           <= idx_nxt;
         cur_type      <= cur_type_nxt;
         cur_upper     <= cur_upper_nxt;
         depth         <= depth_nxt;
         err           <= err_nxt;
         expect_result <= (depth_nxt == '0) && !err_nxt;
      end
   end
endmodule
